memory_access: RTL
==================

Name: memory_access

Overview:
- Stage 4 [Mem] of the 5-stage RV32I pipeline. It consumes the registered [ALU] result, performs load/store transactions on the data-memory bus, and formats load data.
- It registers rd/data into stage 5 [Writeback], producing the mem_rd / mem_rd_w_en / writeback_rd_data / writeback_en signals that operand forwarding and the register file consume.
- It stalls upstream while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mem_en  in  1  stage-4 instruction valid.
- alu_rd  in  5  destination register address.
- alu_rd_w_en  in  1  instruction writes rd.
- alu_rd_data  in  32  ALU result; effective address for load/store.
- rs2_data  in  32  store data (forwarded rs2).
- funct3  in  3  load/store width/sign code.
- is_load  in  1  instruction is LOAD.
- is_store  in  1  instruction is STORE.
- flush  in  1  kill the stage-4 instruction.
- mem_stall  out  1  hold stages 1-3 this cycle.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- dmem_wdata  out  32  write data, lane-replicated.
- dmem_wstrb  out  4  byte enables; 0 on reads.
- dmem_ack  in  1  transaction complete; rdata valid this cycle.
- dmem_rdata  in  32  read word.
- mem_rd  out  5  stage-5 rd address.
- mem_rd_w_en  out  1  stage-5 rd write enable.
- writeback_rd_data  out  32  stage-5 rd value.
- writeback_en  out  1  stage 5 holds a valid instruction.
- load_misaligned  out  1  exception pulse, aligned with writeback_en.
- store_misaligned  out  1  exception pulse, aligned with writeback_en.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE. All registered outputs become 0; dmem_req=0. This applies mid-transaction too: the transaction is abandoned and dmem_req=0 from the next cycle.
- FSM states: IDLE and BUSY.
- IDLE, mem_en=1, non-memory instruction, no flush:
  - Next cycle: writeback_en=1, mem_rd=alu_rd, writeback_rd_data=alu_rd_data, mem_rd_w_en=alu_rd_w_en.
  - mem_stall=0. Latency is 1 cycle.
- IDLE, mem_en=1, load or store, aligned, no flush:
  - mem_stall=1 combinationally.
  - Capture address/data/wstrb/rd/funct3; go to BUSY.
- BUSY:
  - dmem_req=1; addr, we, wdata and wstrb are held stable until dmem_ack is sampled.
  - mem_stall=1 except in the ack cycle.
  - On ack: return to IDLE. The next cycle gives writeback_en=1, plus the formatted load data for a load, or mem_rd_w_en=0 for a store.
  - Minimum load/store latency is 2 cycles (ack in the first req cycle).
- Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - A misaligned access issues no request and no stall.
  - Next cycle: writeback_en=1, mem_rd_w_en=0, and load_misaligned or store_misaligned=1 for exactly one cycle.
- Load format, selected by addr[1:0]:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passthrough.
  - funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Undefined funct3 is treated as word.
- Store format:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb = 0011 or 1100; wdata = halfword replicated ×2.
  - SW: wstrb = 1111.
- rd = x0 forces mem_rd_w_en=0.
- writeback_en=0 in any cycle following no completion: idle, BUSY without ack, or flushed.
- flush in IDLE: the instruction is dropped and nothing is issued.
- flush in BUSY, or flush coincident with ack: the bus transaction still completes (never aborted), the result is discarded, and writeback_en stays 0.
- A new instruction is accepted only in IDLE. Upstream holds its inputs while mem_stall=1.

Decomposition:
- rv32i_header.vh holds the funct3 load/store codes (LB..LHU, SB..SW), `ZERO_REG_ADDR`, and the FSM state encodings.
- Sub-module load_store_align is purely combinational. Inputs: funct3, addr[1:0], store data, read data. Outputs: wstrb, replicated wdata, extended load data, misaligned flag.
- FSM and pipeline registers live in memory_access.

Test Plan:
1. ALU op: mem_en=1, alu_rd=5, alu_rd_data=0x12345678 -> next cycle writeback_en=1, mem_rd=5, writeback_rd_data=0x12345678; mem_stall never 1.
2. LB, addr 0x1003, ack on third req cycle with rdata 0x80FF0011 -> dmem_addr=0x1000, wstrb=0, mem_stall high 3 cycles, writeback_rd_data=0xFFFFFF80 one cycle after ack.
3. SH, addr 0x2002, rs2=0xAAAABEEF, immediate ack -> dmem_we=1, wstrb=1100, wdata=0xBEEFBEEF; writeback_en=1 with mem_rd_w_en=0.
4. LW, addr 0x3001 -> dmem_req stays 0, mem_stall 0, next cycle load_misaligned=1, writeback_en=1, mem_rd_w_en=0.
5. LHU, addr 0x4002, rdata 0x8001FFFF, rd=0 -> writeback_rd_data=0x00008001, mem_rd_w_en=0. Then a load with flush asserted in BUSY -> req held until ack, writeback_en stays 0.
6. rst_n=0 during BUSY with no ack -> next cycle dmem_req=0, writeback_en=0, all outputs 0; a new ALU op is accepted right after reset.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
// Shared definitions for the RV32I memory-access stage:
//   - funct3 codes for loads and stores
//   - the architectural zero register address
//   - FSM state encoding and access-size decoding
package memory_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [4:0] ZERO_REG_ADDR = 5'd0;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    // funct3[1:0] carries the width; any code that is not a byte or
    // halfword (including undefined ones) is handled as a full word.
    function automatic access_size_e decode_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   decode_size = SIZE_BYTE;
            2'b01:   decode_size = SIZE_HALF;
            default: decode_size = SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
// Data-memory bus between the memory-access stage (master) and memory (slave).
//   dmem_req    master -> slave  request valid, held until ack
//   dmem_we     master -> slave  1 = write
//   dmem_addr   master -> slave  word-aligned address
//   dmem_wdata  master -> slave  lane-replicated write data
//   dmem_wstrb  master -> slave  byte enables, 0 on reads
//   dmem_ack    slave -> master  transaction complete, rdata valid
//   dmem_rdata  slave -> master  read word
interface memory_access_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_wstrb;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_access_load_store_align.sv
// load_store_align
// Purely combinational lane steering for loads and stores.
//   funct3      in   load/store width and sign code
//   addr_lo     in   byte offset within the word
//   store_data  in   rs2 value to be stored
//   read_data   in   word returned by memory
//   wstrb       out  byte enables for a store
//   wdata       out  store data replicated across lanes
//   load_data   out  selected and extended load value
//   misaligned  out  access does not respect its natural alignment
module load_store_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    access_size_e size;
    logic [7:0]   rd_byte;
    logic [15:0]  rd_half;

    always_comb begin
        size = decode_size(funct3);

        case (addr_lo)
            2'd0:    rd_byte = read_data[7:0];
            2'd1:    rd_byte = read_data[15:8];
            2'd2:    rd_byte = read_data[23:16];
            default: rd_byte = read_data[31:24];
        endcase
        rd_half = addr_lo[1] ? read_data[31:16] : read_data[15:0];

        wstrb      = 4'b1111;
        wdata      = store_data;
        load_data  = read_data;
        misaligned = 1'b0;

        // funct3[2] set means the unsigned variant (LBU/LHU).
        case (size)
            SIZE_BYTE: begin
                wstrb      = 4'b0001 << addr_lo;
                wdata      = {4{store_data[7:0]}};
                load_data  = funct3[2] ? {24'h0, rd_byte}
                                       : {{24{rd_byte[7]}}, rd_byte};
            end
            SIZE_HALF: begin
                wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = funct3[2] ? {16'h0, rd_half}
                                       : {{16{rd_half[15]}}, rd_half};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// memory_access
// Stage 4 of the RV32I pipeline: issues loads/stores on the data bus,
// formats load data and registers the result into stage 5.
//   clk, rst_n            clock and synchronous active-low reset
//   mem_en .. flush       stage-4 instruction from the ALU stage
//   mem_stall             holds stages 1-3 while a transaction is pending
//   dmem                  data-memory bus (master side)
//   mem_rd, mem_rd_w_en,
//   writeback_rd_data,
//   writeback_en          stage-5 registers for forwarding and the regfile
//   load_misaligned,
//   store_misaligned      one-cycle exception pulses alongside writeback_en
module memory_access
    import memory_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_en,
    input  logic [4:0]             alu_rd,
    input  logic                   alu_rd_w_en,
    input  logic [31:0]            alu_rd_data,
    input  logic [31:0]            rs2_data,
    input  logic [2:0]             funct3,
    input  logic                   is_load,
    input  logic                   is_store,
    input  logic                   flush,
    output logic                   mem_stall,
    memory_access_if.master        dmem,
    output logic [4:0]             mem_rd,
    output logic                   mem_rd_w_en,
    output logic [31:0]            writeback_rd_data,
    output logic                   writeback_en,
    output logic                   load_misaligned,
    output logic                   store_misaligned
);

    mem_state_e        state;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [4:0]        rd_q;
    logic              rd_w_en_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic              load_q;
    logic              flushed_q;

    logic [2:0]        align_funct3;
    logic [1:0]        align_offset;
    logic [3:0]        align_wstrb;
    logic [31:0]       align_wdata;
    logic [31:0]       align_load_data;
    logic              align_misaligned;

    logic              mem_op;
    logic              store_op;
    logic              issue;

    // While BUSY the live inputs still show the held instruction, but the
    // captured copy is used so load formatting never depends on upstream.
    assign align_funct3 = (state == STATE_BUSY) ? funct3_q : funct3;
    assign align_offset = (state == STATE_BUSY) ? offset_q : alu_rd_data[1:0];

    load_store_align u_align (
        .funct3     (align_funct3),
        .addr_lo    (align_offset),
        .store_data (rs2_data),
        .read_data  (dmem.dmem_rdata),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (align_load_data),
        .misaligned (align_misaligned)
    );

    // A load takes priority if both decode flags are ever set together.
    assign mem_op   = is_load | is_store;
    assign store_op = is_store & ~is_load;
    assign issue    = mem_en & ~flush & mem_op & ~align_misaligned;

    // Stall is released in the ack cycle so the next instruction can be
    // presented exactly when the FSM returns to IDLE.
    assign mem_stall = (state == STATE_IDLE) ? issue : ~dmem.dmem_ack;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= STATE_IDLE;
            req_q             <= 1'b0;
            we_q              <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= 32'h0;
            wstrb_q           <= 4'h0;
            rd_q              <= 5'd0;
            rd_w_en_q         <= 1'b0;
            funct3_q          <= 3'd0;
            offset_q          <= 2'd0;
            load_q            <= 1'b0;
            flushed_q         <= 1'b0;
            mem_rd            <= 5'd0;
            mem_rd_w_en       <= 1'b0;
            writeback_rd_data <= 32'h0;
            writeback_en      <= 1'b0;
            load_misaligned   <= 1'b0;
            store_misaligned  <= 1'b0;
        end else begin
            // Stage-5 valid and exception flags are pulses; they are only
            // raised in the cycle after a completion.
            writeback_en     <= 1'b0;
            mem_rd_w_en      <= 1'b0;
            load_misaligned  <= 1'b0;
            store_misaligned <= 1'b0;

            case (state)
                STATE_IDLE: begin
                    if (mem_en && !flush) begin
                        if (!mem_op) begin
                            writeback_en      <= 1'b1;
                            mem_rd            <= alu_rd;
                            writeback_rd_data <= alu_rd_data;
                            mem_rd_w_en       <= alu_rd_w_en && (alu_rd != ZERO_REG_ADDR);
                        end else if (align_misaligned) begin
                            writeback_en      <= 1'b1;
                            mem_rd            <= alu_rd;
                            writeback_rd_data <= alu_rd_data;
                            load_misaligned   <= is_load;
                            store_misaligned  <= store_op;
                        end else begin
                            state     <= STATE_BUSY;
                            req_q     <= 1'b1;
                            we_q      <= store_op;
                            addr_q    <= {alu_rd_data[ADDR_W-1:2], 2'b00};
                            wdata_q   <= align_wdata;
                            wstrb_q   <= store_op ? align_wstrb : 4'h0;
                            rd_q      <= alu_rd;
                            rd_w_en_q <= alu_rd_w_en && !store_op
                                         && (alu_rd != ZERO_REG_ADDR);
                            funct3_q  <= funct3;
                            offset_q  <= alu_rd_data[1:0];
                            load_q    <= !store_op;
                            flushed_q <= 1'b0;
                        end
                    end
                end

                STATE_BUSY: begin
                    // A flush never aborts the bus transaction; it only
                    // suppresses the write-back once the ack arrives.
                    if (dmem.dmem_ack) begin
                        state   <= STATE_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        wstrb_q <= 4'h0;
                        if (!flushed_q && !flush) begin
                            writeback_en      <= 1'b1;
                            mem_rd            <= rd_q;
                            mem_rd_w_en       <= rd_w_en_q;
                            writeback_rd_data <= load_q ? align_load_data : 32'h0;
                        end
                    end else if (flush) begin
                        flushed_q <= 1'b1;
                    end
                end

                default: begin
                    state <= STATE_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
